// File: rtl/regfile_write_arbiter_pkg.sv
// Shared core definitions for the register-file writeback path: widths, the
// zero-register index and the requester encoding.
package regfile_write_arbiter_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ZERO_REG = 0;
   localparam int unsigned STARVE_W = 4;

   typedef enum logic {
      ReqAlu = 1'b0,
      ReqMem = 1'b1
   } req_id_e;

   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] val,
                                                   input logic [STARVE_W-1:0] lim);
      return (val >= lim) ? val : val + STARVE_W'(1);
   endfunction

endpackage

// File: rtl/wb_priority_sel.sv
// Writeback priority select: loads win ties unless the ALU has lost STARVE_MAX
// consecutive cycles, in which case it is force-granted.
module wb_priority_sel
   import regfile_write_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    enable,
   input  logic    alu_valid,
   input  logic    mem_valid,
   output logic    alu_ready,
   output logic    mem_ready,
   output logic    grant,
   output req_id_e grant_id
);

   localparam logic [STARVE_W-1:0] Limit = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                alu_forced;

   assign alu_forced = (starve_q == Limit);

   always_comb begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
      if (enable) begin
         if (mem_valid && !(alu_valid && alu_forced)) begin
            mem_ready = 1'b1;
         end else if (alu_valid) begin
            alu_ready = 1'b1;
         end
      end
   end

   assign grant    = alu_ready | mem_ready;
   assign grant_id = mem_ready ? ReqMem : ReqAlu;

   // Counts only consecutive losses; any idle or granted ALU cycle restarts it.
   always_comb begin
      starve_d = '0;
      if (alu_valid && !alu_ready) begin
         starve_d = sat_inc(starve_q, Limit);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter (ALU and load unit) with a single
// registered write port and a per-register pending-write mask.
module regfile_write_arbiter #(
   parameter int unsigned DATA_W     = regfile_write_arbiter_pkg::DATA_W,
   parameter int unsigned ADDR_W     = regfile_write_arbiter_pkg::ADDR_W,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              aluValid,
   input  logic [ADDR_W-1:0] aluAddr,
   input  logic [DATA_W-1:0] aluData,
   output logic              aluReady,
   input  logic              memValid,
   input  logic [ADDR_W-1:0] memAddr,
   input  logic [DATA_W-1:0] memData,
   output logic              memReady,
   output logic              writeEnable,
   output logic [ADDR_W-1:0] writeAddress,
   output logic [DATA_W-1:0] writeData,
   output logic [31:0]       pendingMask
);
   import regfile_write_arbiter_pkg::*;

   logic              run_q;
   logic              grant;
   req_id_e           grant_id;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d, sel_addr;
   logic [DATA_W-1:0] wdata_q, wdata_d, sel_data;

   // Holds grants off until the first clock edge after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   wb_priority_sel #(
      .STARVE_MAX (STARVE_MAX)
   ) u_sel (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (run_q),
      .alu_valid (aluValid),
      .mem_valid (memValid),
      .alu_ready (aluReady),
      .mem_ready (memReady),
      .grant     (grant),
      .grant_id  (grant_id)
   );

   assign sel_addr = (grant_id == ReqMem) ? memAddr : aluAddr;
   assign sel_data = (grant_id == ReqMem) ? memData : aluData;

   // x0 writes are accepted and tracked on the bus but never strobe the file.
   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (grant) begin
         we_d    = (sel_addr != ADDR_W'(ZERO_REG));
         waddr_d = sel_addr;
         wdata_d = sel_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign writeEnable  = we_q;
   assign writeAddress = waddr_q;
   assign writeData    = wdata_q;

   always_comb begin
      pendingMask = '0;
      for (int unsigned k = 1; k < NUM_REGS; k++) begin
         pendingMask[k] = (aluValid && (aluAddr == ADDR_W'(k))) ||
                          (memValid && (memAddr == ADDR_W'(k))) ||
                          (we_q && (waddr_q == ADDR_W'(k)));
      end
   end

   a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      !(aluReady && memReady));

   a_no_x0_strobe : assert property (@(posedge clk) disable iff (!rst_n)
      writeEnable |-> (writeAddress != ADDR_W'(ZERO_REG)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal checks plus a
// cycle-by-cycle reference model compared on every falling clock edge.
module tb_regfile_write_arbiter;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 5;
   localparam int          SMAX = 4;

   logic          clk;
   logic          rst_n;
   logic          aluValid, memValid;
   logic [AW-1:0] aluAddr, memAddr;
   logic [DW-1:0] aluData, memData;
   logic          aluReady, memReady;
   logic          writeEnable;
   logic [AW-1:0] writeAddress;
   logic [DW-1:0] writeData;
   logic [31:0]   pendingMask;

   int total = 0;
   int bad   = 0;

   regfile_write_arbiter #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .aluValid     (aluValid),
      .aluAddr      (aluAddr),
      .aluData      (aluData),
      .aluReady     (aluReady),
      .memValid     (memValid),
      .memAddr      (memAddr),
      .memData      (memData),
      .memReady     (memReady),
      .writeEnable  (writeEnable),
      .writeAddress (writeAddress),
      .writeData    (writeData),
      .pendingMask  (pendingMask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who wins is decided from the arbitration rules directly.
   int          m_losses = 0;
   bit          m_run    = 0;
   bit          m_we     = 0;
   logic [4:0]  m_addr   = '0;
   logic [31:0] m_data   = '0;
   int          n_losses = 0;
   bit          n_we     = 0;
   logic [4:0]  n_addr   = '0;
   logic [31:0] n_data   = '0;
   bit          e_ar, e_mr;
   logic [31:0] e_pm;

   always @(negedge clk) begin
      e_ar = 0;
      e_mr = 0;
      if (rst_n && m_run) begin
         if (aluValid && memValid) begin
            if (m_losses == SMAX) e_ar = 1;
            else                  e_mr = 1;
         end else begin
            e_ar = aluValid;
            e_mr = memValid;
         end
      end
      e_pm = 0;
      for (int k = 1; k < 32; k++) begin
         if ((aluValid && int'(aluAddr) == k) || (memValid && int'(memAddr) == k) ||
             (m_we && int'(m_addr) == k)) e_pm[k] = 1'b1;
      end
      chk("m_alu_ready", aluReady, e_ar);
      chk("m_mem_ready", memReady, e_mr);
      chk("m_we", writeEnable, m_we);
      chk("m_waddr", writeAddress, m_addr);
      chk("m_wdata", writeData, m_data);
      chk("m_pending", pendingMask, e_pm);
      n_we = 0;
      n_addr = m_addr;
      n_data = m_data;
      if (e_ar) begin
         n_we = (aluAddr != 0); n_addr = aluAddr; n_data = aluData;
      end else if (e_mr) begin
         n_we = (memAddr != 0); n_addr = memAddr; n_data = memData;
      end
      if (aluValid && !e_ar) n_losses = (m_losses + 1 > SMAX) ? SMAX : m_losses + 1;
      else                   n_losses = 0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 0; m_we <= 0; m_addr <= '0; m_data <= '0; m_losses <= 0;
      end else begin
         m_run <= 1; m_we <= n_we; m_addr <= n_addr; m_data <= n_data;
         m_losses <= n_losses;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 0; aluValid = 0; memValid = 0;
      aluAddr = 0; memAddr = 0; aluData = 0; memData = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", writeEnable, 0);
      chk("rst_addr", writeAddress, 0);
      chk("rst_data", writeData, 0);
      chk("rst_ardy", aluReady, 0);
      rst_n = 1;
      cyc();

      // Lone ALU request
      aluValid = 1; aluAddr = 5; aluData = 32'hDEADBEEF;
      #1;
      chk("lone_ardy", aluReady, 1);
      chk("lone_mrdy", memReady, 0);
      chk("lone_pm5", pendingMask[5], 1);
      cyc(); aluValid = 0; #1;
      chk("lone_we", writeEnable, 1);
      chk("lone_addr", writeAddress, 5);
      chk("lone_data", writeData, 32'hDEADBEEF);
      cyc();
      chk("idle_we", writeEnable, 0);
      chk("hold_addr", writeAddress, 5);
      chk("hold_data", writeData, 32'hDEADBEEF);

      // Simultaneous requests: load first, ALU next
      aluValid = 1; aluAddr = 3; aluData = 32'h11;
      memValid = 1; memAddr = 4; memData = 32'h22;
      #1;
      chk("sim_mrdy", memReady, 1);
      chk("sim_ardy", aluReady, 0);
      cyc(); memValid = 0; #1;
      chk("sim_w1_addr", writeAddress, 4);
      chk("sim_w1_data", writeData, 32'h22);
      chk("sim_ardy2", aluReady, 1);
      cyc(); aluValid = 0; #1;
      chk("sim_w2_addr", writeAddress, 3);
      chk("sim_w2_data", writeData, 32'h11);

      // Starvation: ALU loses four cycles, wins the fifth
      aluValid = 1; aluAddr = 9; aluData = 32'h99;
      memValid = 1; memAddr = 10; memData = 32'h0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("starve_lose", aluReady, 0);
         cyc(); memAddr = 5'(11 + i); memData = 32'(i + 1);
      end
      #1;
      chk("starve_win_ardy", aluReady, 1);
      chk("starve_win_mrdy", memReady, 0);
      cyc(); aluAddr = 8; aluData = 32'h88; #1;
      chk("starve_w_addr", writeAddress, 9);
      chk("starve_w_data", writeData, 32'h99);
      chk("starve_clr_ardy", aluReady, 0);
      chk("starve_clr_mrdy", memReady, 1);
      cyc(); memValid = 0; #1;
      chk("starve_mem_addr", writeAddress, 14);
      chk("starve_alu2_ardy", aluReady, 1);
      cyc(); aluValid = 0; #1;
      chk("starve_alu2_addr", writeAddress, 8);

      // x0 write
      memValid = 1; memAddr = 0; memData = 32'hFFFFFFFF;
      #1;
      chk("x0_mrdy", memReady, 1);
      chk("x0_pm0", pendingMask[0], 0);
      cyc(); memValid = 0; #1;
      chk("x0_we", writeEnable, 0);
      chk("x0_addr", writeAddress, 0);
      chk("x0_data", writeData, 32'hFFFFFFFF);
      chk("x0_pm", pendingMask, 0);

      // Same-address race on x7
      aluValid = 1; aluAddr = 7; aluData = 32'hA;
      memValid = 1; memAddr = 7; memData = 32'hB;
      #1;
      chk("race_mrdy", memReady, 1);
      chk("race_pm7a", pendingMask[7], 1);
      cyc(); memValid = 0; #1;
      chk("race_w1", {writeEnable, writeAddress, writeData}, {1'b1, 5'd7, 32'hB});
      chk("race_ardy", aluReady, 1);
      chk("race_pm7b", pendingMask[7], 1);
      cyc(); aluValid = 0; #1;
      chk("race_w2", {writeEnable, writeAddress, writeData}, {1'b1, 5'd7, 32'hA});
      chk("race_pm7c", pendingMask[7], 1);
      cyc();
      chk("race_pm7d", pendingMask[7], 0);
      chk("race_we_end", writeEnable, 0);

      // Reset dropped mid-cycle while a write is on the port
      aluValid = 1; aluAddr = 12; aluData = 32'h55;
      cyc(); aluValid = 0; #1;
      chk("mr_we_before", writeEnable, 1);
      #1 rst_n = 0;
      #1;
      chk("mr_we", writeEnable, 0);
      chk("mr_addr", writeAddress, 0);
      chk("mr_data", writeData, 0);
      aluValid = 1; aluAddr = 13; aluData = 32'h66;
      #1;
      chk("mr_ardy", aluReady, 0);
      chk("mr_pm", pendingMask, 32'h0000_2000);
      @(posedge clk);
      #1 rst_n = 1;
      #1;
      chk("mr_rel_ardy", aluReady, 0);
      chk("mr_rel_mrdy", memReady, 0);
      cyc(); #1;
      chk("mr_run_ardy", aluReady, 1);
      cyc(); aluValid = 0; #1;
      chk("mr_w", {writeEnable, writeAddress, writeData}, {1'b1, 5'd13, 32'h66});
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
